// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine: FSM state encoding, algorithm
// selector constants and the width helper for the common power-of-two
// shift count used by the binary algorithm.
package gcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } gcd_state_e;

    localparam int MODE_SUB = 0;  // subtractive Euclid
    localparam int MODE_BIN = 1;  // binary Stein

    // Bits needed to hold a shift count in the range 0..width.
    function automatic int k_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/gcd_step_unit.sv
// Combinational datapath for one GCD evaluation cycle.
// Ports:
//   i_a, i_b  current operands
//   i_k       common factor-of-two shift count (binary mode only)
//   o_a, o_b  operands after one step
//   o_k       shift count after one step
//   o_term    termination detected this cycle (no step taken)
//   o_result  final GCD, valid when o_term=1
module gcd_step_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int MODE  = MODE_SUB,
    parameter int KW    = 5
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [KW-1:0]    i_k,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic [KW-1:0]    o_k,
    output logic             o_term,
    output logic [WIDTH-1:0] o_result
);

    // Termination checks in priority order, otherwise one algorithm step.
    always_comb begin
        o_a      = i_a;
        o_b      = i_b;
        o_k      = i_k;
        o_term   = 1'b0;
        o_result = '0;
        if (i_a == '0) begin
            o_term   = 1'b1;
            o_result = i_b << i_k;
        end else if (i_b == '0) begin
            o_term   = 1'b1;
            o_result = i_a << i_k;
        end else if (i_a == i_b) begin
            o_term   = 1'b1;
            o_result = i_a << i_k;
        end else if (MODE == MODE_BIN) begin
            // Shifting the true GCD back by k is exact: it never overflows WIDTH.
            if (!i_a[0] && !i_b[0]) begin
                o_a = i_a >> 1;
                o_b = i_b >> 1;
                o_k = i_k + KW'(1);
            end else if (!i_a[0]) begin
                o_a = i_a >> 1;
            end else if (!i_b[0]) begin
                o_b = i_b >> 1;
            end else if (i_a > i_b) begin
                o_a = i_a - i_b;
            end else begin
                o_b = i_b - i_a;
            end
        end else begin
            if (i_a > i_b) begin
                o_a = i_a - i_b;
            end else begin
                o_b = i_b - i_a;
            end
        end
    end

endmodule

// File: rtl/gcd_engine.sv
// Iterative GCD engine with valid/ready handshake on both sides.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a_in, b_in loaded in parallel)
//   out_valid/out_ready result handshake
//   gcd_out             GCD of the last completed job
//   iter_count          step cycles used by the current/last job (saturating)
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int MODE  = MODE_SUB,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd_out,
    output logic [CNT_W-1:0] iter_count
);

    localparam int KW = k_width(WIDTH);

    gcd_state_e         r_state;
    gcd_state_e         w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [KW-1:0]      r_k;
    logic [WIDTH-1:0]   r_gcd;
    logic [CNT_W-1:0]   r_iter;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [WIDTH-1:0]   w_a_nxt;
    logic [WIDTH-1:0]   w_b_nxt;
    logic [KW-1:0]      w_k_nxt;
    logic               w_term;
    logic [WIDTH-1:0]   w_result;

    gcd_step_unit #(
        .WIDTH (WIDTH),
        .MODE  (MODE),
        .KW    (KW)
    ) u_step (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_k      (r_k),
        .o_a      (w_a_nxt),
        .o_b      (w_b_nxt),
        .o_k      (w_k_nxt),
        .o_term   (w_term),
        .o_result (w_result)
    );

    // Next-state logic for the IDLE/CALC/DONE controller.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = ST_CALC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (w_term) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register plus handshake flags registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
        end
    end

    // Operand, shift-count, result and iteration-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_k    <= '0;
            r_gcd  <= '0;
            r_iter <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a    <= a_in;
                        r_b    <= b_in;
                        r_k    <= '0;
                        r_iter <= '0;
                    end
                end
                ST_CALC: begin
                    if (w_term) begin
                        // Terminating cycle publishes the result and is not counted.
                        r_gcd <= w_result;
                    end else begin
                        r_a <= w_a_nxt;
                        r_b <= w_b_nxt;
                        r_k <= w_k_nxt;
                        if (r_iter != {CNT_W{1'b1}}) begin
                            r_iter <= r_iter + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_a <= r_a;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign gcd_out    = r_gcd;
    assign iter_count = r_iter;

endmodule
